// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronise, glitch-filter, deserialise 11-bit frames.
// Optional feature: define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 48000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       ena,
  output logic       err
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic              fclk_q, fclk_d;
  logic [FCNT_W-1:0] filt_cnt_q, filt_cnt_d;
  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0]        code_q, code_d;
  logic              ena_q, ena_d;
  logic              err_q, err_d;
  logic              fall_c;
  logic              par_ok_c;

`ifdef PS2_RX_PARITY_CHECK_EN
  logic              par_q, par_d;
  assign par_ok_c = ^{shift_q, par_q};
`else
  assign par_ok_c = 1'b1;
`endif

  // Filtered clock flips only after FILTER_LEN consecutive opposite samples
  always_comb begin
    fclk_d     = fclk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != fclk_q) begin
      if (filt_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        fclk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCNT_W'(1);
      end
    end
  end

  assign fall_c = fclk_q & ~fclk_d;

  // Frame FSM; a fall always takes priority over the timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    code_d    = code_q;
    ena_d     = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (fall_c) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_d   = dat_s2_q;
`endif
          state_d = STOP;
        end
        STOP: begin
          if (dat_s2_q && par_ok_c) begin
            code_d = shift_q;
            ena_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fclk_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      code_q     <= 8'h00;
      ena_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
      fclk_q     <= fclk_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      code_q     <= code_d;
      ena_q      <= ena_d;
      err_q      <= err_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign code = code_q;
  assign ena  = ena_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx with a shortened timeout and PS/2 bit period.
module tb_ps2_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 40;
  localparam int LAT         = 2 + FILTER_LEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       ena, err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ena_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int glitch_cnt = 0;
  int ena_cyc  = 0;
  int err_cyc  = 0;
  int last_fall_cyc = 0;
  logic [7:0] codes [0:31];
  logic [7:0] prev_code;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .code(code), .ena(ena), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: pulse counts, timestamps, and code changing without ena
  always @(negedge clk) begin
    if (ena === 1'b1) begin
      if (ena_cnt < 32) codes[ena_cnt] = code;
      ena_cnt = ena_cnt + 1;
      ena_cyc = cyc;
    end
    if (err === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (ena === 1'b1 && err === 1'b1) both_cnt = both_cnt + 1;
    if (rst_n === 1'b1 && code !== prev_code && ena !== 1'b1) glitch_cnt = glitch_cnt + 1;
    prev_code = code;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input int nbits, input int glitch_at);
    logic [10:0] fr;
    fr = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) glitch();
      ps2_dat = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(5);
    n_checks++; if (code !== 8'h00) begin n_fail++; $display("FAIL reset_code got=%h exp=00", code); end
    n_checks++; if (ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena got=%b exp=0", ena); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_single();
    int e0, r0;
    e0 = ena_cnt; r0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    wait_cyc(HALF);
    n_checks++; if (ena_cnt - e0 !== 1) begin n_fail++; $display("FAIL t1_ena_count got=%0d exp=1", ena_cnt - e0); end
    n_checks++; if (code !== 8'h1C) begin n_fail++; $display("FAIL t1_code got=%h exp=1c", code); end
    n_checks++; if (err_cnt - r0 !== 0) begin n_fail++; $display("FAIL t1_err_count got=%0d exp=0", err_cnt - r0); end
    n_checks++; if (ena_cyc - last_fall_cyc !== LAT) begin n_fail++; $display("FAIL t1_ena_latency got=%0d exp=%0d", ena_cyc - last_fall_cyc, LAT); end
  endtask

  task automatic test_back_to_back();
    int e0, r0;
    e0 = ena_cnt; r0 = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    wait_cyc(HALF);
    n_checks++; if (ena_cnt - e0 !== 2) begin n_fail++; $display("FAIL t2_ena_count got=%0d exp=2", ena_cnt - e0); end
    n_checks++; if (codes[e0] !== 8'hF0) begin n_fail++; $display("FAIL t2_first_code got=%h exp=f0", codes[e0]); end
    n_checks++; if (codes[e0+1] !== 8'h1C) begin n_fail++; $display("FAIL t2_second_code got=%h exp=1c", codes[e0+1]); end
    n_checks++; if (err_cnt - r0 !== 0) begin n_fail++; $display("FAIL t2_err_count got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_glitch();
    int e0, r0;
    e0 = ena_cnt; r0 = err_cnt;
    glitch();
    wait_cyc(30);
    n_checks++; if (ena_cnt - e0 + err_cnt - r0 !== 0) begin n_fail++; $display("FAIL t3_idle_glitch pulses got=%0d exp=0", ena_cnt - e0 + err_cnt - r0); end
    send_frame(8'h3C, 1'b0, 1'b1, 11, 4);
    wait_cyc(HALF);
    n_checks++; if (ena_cnt - e0 !== 1) begin n_fail++; $display("FAIL t3_ena_count got=%0d exp=1", ena_cnt - e0); end
    n_checks++; if (code !== 8'h3C) begin n_fail++; $display("FAIL t3_code got=%h exp=3c", code); end
    n_checks++; if (err_cnt - r0 !== 0) begin n_fail++; $display("FAIL t3_err_count got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_bad_stop();
    int e0, r0;
    e0 = ena_cnt; r0 = err_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 11, -1);
    wait_cyc(HALF);
    n_checks++; if (err_cnt - r0 !== 1) begin n_fail++; $display("FAIL t4_err_count got=%0d exp=1", err_cnt - r0); end
    n_checks++; if (err_cyc - last_fall_cyc !== LAT) begin n_fail++; $display("FAIL t4_err_latency got=%0d exp=%0d", err_cyc - last_fall_cyc, LAT); end
    n_checks++; if (ena_cnt - e0 !== 0) begin n_fail++; $display("FAIL t4_ena_count got=%0d exp=0", ena_cnt - e0); end
    n_checks++; if (code !== 8'h3C) begin n_fail++; $display("FAIL t4_code got=%h exp=3c", code); end
  endtask

  task automatic test_parity();
    int e0, r0;
    e0 = ena_cnt; r0 = err_cnt;
    send_frame(8'h29, 1'b1, 1'b1, 11, -1);
    wait_cyc(HALF);
`ifdef PS2_RX_PARITY_CHECK_EN
    n_checks++; if (err_cnt - r0 !== 1) begin n_fail++; $display("FAIL t5_err_count got=%0d exp=1", err_cnt - r0); end
    n_checks++; if (ena_cnt - e0 !== 0) begin n_fail++; $display("FAIL t5_ena_count got=%0d exp=0", ena_cnt - e0); end
    n_checks++; if (code !== 8'h3C) begin n_fail++; $display("FAIL t5_code got=%h exp=3c", code); end
`else
    n_checks++; if (err_cnt - r0 !== 0) begin n_fail++; $display("FAIL t5_err_count got=%0d exp=0", err_cnt - r0); end
    n_checks++; if (ena_cnt - e0 !== 1) begin n_fail++; $display("FAIL t5_ena_count got=%0d exp=1", ena_cnt - e0); end
    n_checks++; if (code !== 8'h29) begin n_fail++; $display("FAIL t5_code got=%h exp=29", code); end
`endif
  endtask

  task automatic test_timeout();
    int e0, r0, dt;
    e0 = ena_cnt; r0 = err_cnt;
    send_frame(8'h76, 1'b0, 1'b1, 5, -1);
    wait_cyc(TIMEOUT_CYC + 100);
    dt = err_cyc - last_fall_cyc;
    n_checks++; if (err_cnt - r0 !== 1) begin n_fail++; $display("FAIL t6_timeout_err got=%0d exp=1", err_cnt - r0); end
    n_checks++; if (dt < TIMEOUT_CYC + LAT || dt > TIMEOUT_CYC + LAT + 2) begin n_fail++; $display("FAIL t6_timeout_delay got=%0d exp=%0d..%0d", dt, TIMEOUT_CYC + LAT, TIMEOUT_CYC + LAT + 2); end
    n_checks++; if (ena_cnt - e0 !== 0) begin n_fail++; $display("FAIL t6_timeout_ena got=%0d exp=0", ena_cnt - e0); end
    send_frame(8'h76, 1'b0, 1'b1, 11, -1);
    wait_cyc(HALF);
    n_checks++; if (ena_cnt - e0 !== 1) begin n_fail++; $display("FAIL t6_recover_ena got=%0d exp=1", ena_cnt - e0); end
    n_checks++; if (code !== 8'h76) begin n_fail++; $display("FAIL t6_recover_code got=%h exp=76", code); end

    e0 = ena_cnt; r0 = err_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 5, -1);
    wait_cyc(5);
    rst_n = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(TIMEOUT_CYC + 100);
    n_checks++; if (err_cnt - r0 !== 0) begin n_fail++; $display("FAIL t6_reset_err got=%0d exp=0", err_cnt - r0); end
    n_checks++; if (code !== 8'h00) begin n_fail++; $display("FAIL t6_reset_code got=%h exp=00", code); end
    send_frame(8'h12, 1'b0, 1'b1, 11, -1);
    wait_cyc(HALF);
    n_checks++; if (ena_cnt - e0 !== 1) begin n_fail++; $display("FAIL t6_post_reset_ena got=%0d exp=1", ena_cnt - e0); end
    n_checks++; if (code !== 8'h12) begin n_fail++; $display("FAIL t6_post_reset_code got=%h exp=12", code); end
  endtask

  task automatic test_invariants();
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL ena_err_overlap got=%0d exp=0", both_cnt); end
    n_checks++; if (glitch_cnt !== 0) begin n_fail++; $display("FAIL code_change_without_ena got=%0d exp=0", glitch_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_bad_stop();
    test_parity();
    test_timeout();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
